// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Buffered UART transmitter. A FIFO of PAYLOAD_BITS-wide words
//             feeds a start/data/[parity]/stop serializer. Each line bit is
//             held for CPB = CLK_HZ/BIT_RATE clocks. All outputs come
//             straight from flops.
//  Options  : `define UART_TX_FLOWCTRL_EN adds an active-low cts_n input
//             (two-flop synchronised). A new frame starts only while it is low.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_HZ       = 50000000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [PAYLOAD_BITS-1:0]       wr_data,
`ifdef UART_TX_FLOWCTRL_EN
    input  logic                          cts_n,
`endif
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          tx_busy,
    output logic                          uart_txd
);

    localparam int CPB = CLK_HZ / BIT_RATE;
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int BW  = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [PAYLOAD_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [LW-1:0]           r_level;
    logic                    r_full;
    logic                    r_empty;
    logic                    r_overflow;

    // Serializer
    state_t                  r_state;
    logic [CW-1:0]           r_baud;
    logic [BW-1:0]           r_bit;
    logic [PAYLOAD_BITS-1:0] r_shift;
    logic                    r_par;
    logic                    r_txd;
    logic                    r_busy;

    logic                    w_cts_ok;
    logic                    w_push;
    logic                    w_pop;
    logic [LW-1:0]           w_level_nxt;
    logic [PAYLOAD_BITS-1:0] w_head;
    logic                    w_par_bit;

`ifdef UART_TX_FLOWCTRL_EN
    logic r_cts_s1;
    logic r_cts_s2;

    // Two-flop synchroniser for the asynchronous clear-to-send input
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cts_s1 <= 1'b1;
            r_cts_s2 <= 1'b1;
        end else begin
            r_cts_s1 <= cts_n;
            r_cts_s2 <= r_cts_s1;
        end
    end

    assign w_cts_ok = ~r_cts_s2;
`else
    assign w_cts_ok = 1'b1;
`endif

    // full is the pre-pop view, so a write into a full FIFO is dropped even
    // when the serializer pops in the same cycle.
    assign w_push      = wr_en & ~r_full;
    assign w_pop       = (r_state == S_IDLE) & ~r_empty & w_cts_ok;
    assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_par_bit   = (PARITY == 1) ? ~(^w_head) : (^w_head);

    // FIFO storage write port (no reset needed on the data array)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers, occupancy flags and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level    <= w_level_nxt;
            r_full     <= (w_level_nxt == LW'(FIFO_DEPTH));
            r_empty    <= (w_level_nxt == '0);
            r_overflow <= r_overflow | (wr_en & r_full);
        end
    end

    // Serializer FSM; the line flop follows the state held in the cycle that
    // just ended, so every bit (start included) spans exactly CPB clocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_busy <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_txd  <= 1'b1;
                    r_busy <= (w_level_nxt != '0);
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_par   <= w_par_bit;
                        r_baud  <= CW'(CPB - 1);
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    r_txd <= 1'b0;
                    if (r_baud != '0) begin
                        r_baud <= r_baud - CW'(1);
                    end else begin
                        r_baud  <= CW'(CPB - 1);
                        r_bit   <= '0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    r_txd <= r_shift[0];
                    if (r_baud != '0) begin
                        r_baud <= r_baud - CW'(1);
                    end else begin
                        r_baud  <= CW'(CPB - 1);
                        r_shift <= r_shift >> 1;
                        if (r_bit == BW'(PAYLOAD_BITS - 1)) begin
                            r_bit   <= '0;
                            r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit <= r_bit + BW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    r_txd <= r_par;
                    if (r_baud != '0) begin
                        r_baud <= r_baud - CW'(1);
                    end else begin
                        r_baud  <= CW'(CPB - 1);
                        r_bit   <= '0;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    r_txd <= 1'b1;
                    if (r_baud != '0) begin
                        r_baud <= r_baud - CW'(1);
                    end else if (r_bit == BW'(STOP_BITS - 1)) begin
                        r_bit   <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= (w_level_nxt != '0);
                    end else begin
                        r_baud <= CW'(CPB - 1);
                        r_bit  <= r_bit + BW'(1);
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign full     = r_full;
    assign empty    = r_empty;
    assign level    = r_level;
    assign overflow = r_overflow;
    assign tx_busy  = r_busy;
    assign uart_txd = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Purpose  : Self-checking bench for uart_tx_fifo. Three configurations run
//             side by side against a queue-based frame model, with a few
//             hand-computed line/flag expectations on top.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CLK_HZ   = 1000000;
    localparam int BIT_RATE = 100000;
    localparam int CPB      = CLK_HZ / BIT_RATE;
    localparam int NDUT     = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [8:0] wr_data = '0;
`ifdef UART_TX_FLOWCTRL_EN
    logic       cts_n = 1'b0;
`endif
    logic       started = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [NDUT-1:0] txd_v, busy_v, full_v, empty_v, ovf_v;
    logic [4:0]      lvl0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0d required=%0d at %0t", name, id, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int PB    = (g == 2) ? 7 : 8;
        localparam int PARI  = (g == 0) ? 0 : ((g == 1) ? 2 : 1);
        localparam int STOPB = (g == 1) ? 2 : 1;
        localparam int D     = (g == 2) ? 4 : 16;
        localparam int FL    = (1 + PB + ((PARI != 0) ? 1 : 0) + STOPB) * CPB;

        logic [$clog2(D):0] lvl;

        uart_tx_fifo #(
            .CLK_HZ      (CLK_HZ),
            .BIT_RATE    (BIT_RATE),
            .PAYLOAD_BITS(PB),
            .FIFO_DEPTH  (D),
            .PARITY      (PARI),
            .STOP_BITS   (STOPB)
        ) u_dut (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr_en),
            .wr_data (wr_data[PB-1:0]),
`ifdef UART_TX_FLOWCTRL_EN
            .cts_n   (cts_n),
`endif
            .full    (full_v[g]),
            .empty   (empty_v[g]),
            .level   (lvl),
            .overflow(ovf_v[g]),
            .tx_busy (busy_v[g]),
            .uart_txd(txd_v[g])
        );

        if (g == 0) begin : g_tap
            assign lvl0 = 5'(lvl);
        end

        // Model: queue of pending words, plus the line image of the frame in
        // flight and the number of clocks it still occupies the serializer.
        int   mq[$];
        int   fb[16];
        int   rem = 0;
        logic m_txd = 1'b1;
        logic m_ovf = 1'b0;
        logic s1 = 1'b1;
        logic s2 = 1'b1;

        always @(posedge clk) begin
            bit was_full;
            bit go;
            int w;
            int ones;
            was_full = (mq.size() == D);
`ifdef UART_TX_FLOWCTRL_EN
            go = (s2 == 1'b0);
`else
            go = 1'b1;
`endif
            if (reset) begin
                mq.delete();
                rem   = 0;
                m_txd = 1'b1;
                m_ovf = 1'b0;
                s1    = 1'b1;
                s2    = 1'b1;
            end else begin
                m_txd = (rem > 0) ? (fb[(FL - rem) / CPB] != 0) : 1'b1;
                if (rem > 0) begin
                    rem--;
                end else if (mq.size() > 0 && go) begin
                    w    = mq.pop_front();
                    ones = $countones(w);
                    for (int i = 0; i < 16; i++) fb[i] = 1;
                    fb[0] = 0;
                    for (int i = 0; i < PB; i++) fb[1 + i] = (w >> i) & 1;
                    if (PARI == 2) fb[1 + PB] = ones % 2;
                    else if (PARI == 1) fb[1 + PB] = 1 - (ones % 2);
                    rem = FL;
                end
                if (wr_en) begin
                    if (was_full) m_ovf = 1'b1;
                    else mq.push_back(int'(wr_data[PB-1:0]));
                end
`ifdef UART_TX_FLOWCTRL_EN
                s2 = s1;
                s1 = cts_n;
`endif
            end
        end

        // Per-cycle comparison against the model, away from the active edge
        always @(negedge clk) begin
            if (started) begin
                chk("txd",      g, 32'(txd_v[g]),   32'(m_txd));
                chk("level",    g, 32'(lvl),        32'(mq.size()));
                chk("empty",    g, 32'(empty_v[g]), 32'(mq.size() == 0));
                chk("full",     g, 32'(full_v[g]),  32'(mq.size() == D));
                chk("overflow", g, 32'(ovf_v[g]),   32'(m_ovf));
                chk("busy",     g, 32'(busy_v[g]),  32'(rem > 0 || mq.size() > 0));
            end
        end
    end

    task automatic write_word(input logic [8:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    initial begin
        logic [9:0] a5_line;
        a5_line = {1'b1, 8'hA5, 1'b0};

        reset = 1'b1;
        @(negedge clk);
        started = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_txd",   0, 32'(txd_v[0]),   1);
        chk("rst_empty", 0, 32'(empty_v[0]), 1);
        chk("rst_full",  0, 32'(full_v[0]),  0);
        chk("rst_level", 0, 32'(lvl0),       0);
        chk("rst_ovf",   0, 32'(ovf_v[0]),   0);
        chk("rst_busy",  0, 32'(busy_v[0]),  0);
        repeat (3) @(negedge clk);

        // Single 0xA5 frame: sample each bit mid-slot
        write_word(9'h0A5);
        repeat (6) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            chk("a5_bit", 0, 32'(txd_v[0]), 32'(a5_line[k]));
            repeat (10) @(negedge clk);
        end
        chk("a5_busy_done", 0, 32'(busy_v[0]), 0);
        repeat (30) @(negedge clk);

        // Parity and stop-bit length on the alternate configurations
        write_word(9'h007);
        repeat (86) @(negedge clk);
        chk("par_odd", 2, 32'(txd_v[2]), 0);
        repeat (10) @(negedge clk);
        chk("par_even", 1, 32'(txd_v[1]), 1);
        repeat (24) @(negedge clk);
        chk("stop2_busy", 1, 32'(busy_v[1]), 1);
        @(negedge clk);
        chk("stop2_idle", 1, 32'(busy_v[1]), 0);
        repeat (30) @(negedge clk);

        // 18 back-to-back writes: 17 accepted, 18th dropped
        wr_en = 1'b1;
        for (int i = 0; i < 18; i++) begin
            wr_data = 9'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk("burst_full",  0, 32'(full_v[0]), 1);
        chk("burst_ovf",   0, 32'(ovf_v[0]),  1);
        chk("burst_level", 0, 32'(lvl0),      16);
        repeat (1800) @(negedge clk);
        chk("burst_drain", 0, 32'(empty_v[0]), 1);

        // Reset during data bit 3 with five words queued
        wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = 9'(8'h30 + i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_level", 0, 32'(lvl0),     5);
        chk("mid_ovf",   0, 32'(ovf_v[0]), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst2_txd",   0, 32'(txd_v[0]),   1);
        chk("rst2_empty", 0, 32'(empty_v[0]), 1);
        chk("rst2_level", 0, 32'(lvl0),       0);
        chk("rst2_ovf",   0, 32'(ovf_v[0]),   0);
        repeat (300) @(negedge clk);
        chk("rst2_quiet", 0, 32'(busy_v[0]), 0);

        // Write coinciding with a pop keeps level at 1
        write_word(9'h011);
        chk("wp_level_a", 0, 32'(lvl0), 1);
        write_word(9'h022);
        chk("wp_level_b", 0, 32'(lvl0), 1);
        repeat (250) @(negedge clk);

`ifdef UART_TX_FLOWCTRL_EN
        // Clear-to-send gating
        cts_n = 1'b1;
        repeat (5) @(negedge clk);
        write_word(9'h055);
        write_word(9'h00F);
        repeat (20) @(negedge clk);
        chk("cts_hold_txd",  0, 32'(txd_v[0]),  1);
        chk("cts_hold_busy", 0, 32'(busy_v[0]), 1);
        cts_n = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 4 && !seen; i++) begin
                @(negedge clk);
                if (txd_v[0] == 1'b0) seen = 1'b1;
            end
            chk("cts_start", 0, 32'(seen), 1);
        end
        repeat (30) @(negedge clk);
        cts_n = 1'b1;
        repeat (120) @(negedge clk);
        chk("cts_held_level", 0, 32'(lvl0),      1);
        chk("cts_held_busy",  0, 32'(busy_v[0]), 1);
        chk("cts_held_txd",   0, 32'(txd_v[0]),  1);
        cts_n = 1'b0;
        repeat (150) @(negedge clk);
`endif

        // Randomized traffic with bursts and occasional resets
        for (int ph = 0; ph < 30; ph++) begin
            int prob;
            prob = (ph % 5 == 4) ? 60 : 2;
            for (int c = 0; c < 500; c++) begin
                wr_en   = ($urandom_range(0, 99) < prob);
                wr_data = 9'($urandom_range(0, 511));
                reset   = ($urandom_range(0, 2999) == 0);
`ifdef UART_TX_FLOWCTRL_EN
                if ($urandom_range(0, 199) == 0) cts_n = ~cts_n;
`endif
                @(negedge clk);
            end
        end
        wr_en = 1'b0;
        reset = 1'b0;
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
